// File: rtl/trig_ctrl.sv
// trig_ctrl: scope edge trigger with hysteresis arming and fixed-length capture sequencer.
// Optional macro TRIG_AUTO_EN adds an auto-trigger timeout counted in accepted samples.
module trig_ctrl #(
  parameter int DEPTH_LOG2 = 12,
  parameter int HYST = 4,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic [7:0] trig_level,
  input  logic       trig_slope,
  input  logic       rearm,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       armed,
  output logic       capture_done,
  output logic       auto_trig
);
  typedef enum logic [1:0] {ARM, WAIT, CAPTURE, DONE} state_t;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;
  state_t state, state_nxt;
  logic [7:0] lvl, lo, hi;
  logic [8:0] hi_w;
  logic slope, arm_hit, trig_hit, auto_hit, fwd;
  logic [DEPTH_LOG2:0] cnt;
  // Arming thresholds saturate at the code range ends.
  assign hi_w = {1'b0, lvl} + 9'(HYST);
  assign hi = hi_w[8] ? 8'hff : hi_w[7:0];
  assign lo = ({1'b0, lvl} < 9'(HYST)) ? 8'd0 : lvl - 8'(HYST);
  assign arm_hit = slope ? sample_data >= hi : sample_data <= lo;
  assign trig_hit = slope ? sample_data <= lvl : sample_data >= lvl;
  assign armed = state == ARM || state == WAIT;
  assign capture_done = state == DONE;
`ifdef TRIG_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign auto_hit = (tcnt + 1'b1) == TW'(AUTO_TIMEOUT);
  always_ff @(posedge osc_clk) begin
    if (reset || rearm) begin
      tcnt <= '0;
      auto_trig <= 1'b0;
    end else begin
      if (sample_valid && armed) tcnt <= tcnt + 1'b1;
      if (fwd && armed && !(state == WAIT && trig_hit)) auto_trig <= 1'b1;
    end
  end
`else
  assign auto_hit = 1'b0;
  assign auto_trig = 1'b0;
`endif
  // A sample in ARM can only arm; the trigger is checked from WAIT onwards.
  always_comb begin
    fwd = !rearm && sample_valid && (state == CAPTURE || (armed && auto_hit) || (state == WAIT && trig_hit));
    state_nxt = rearm ? ARM
              : fwd ? ((cnt + 1'b1) == FULL ? DONE : CAPTURE)
              : (sample_valid && state == ARM && arm_hit) ? WAIT : state;
  end
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state <= ARM;
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= 8'd0;
      lvl <= trig_level;
      slope <= trig_slope;
    end else begin
      state <= state_nxt;
      out_valid <= fwd;
      if (fwd) out_data <= sample_data;
      if (rearm) begin
        cnt <= '0;
        lvl <= trig_level;
        slope <= trig_slope;
      end else if (fwd) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_trig_ctrl.sv
// tb_trig_ctrl: randomized + directed scoreboard bench for trig_ctrl against a behavioural model.
module tb_trig_ctrl;
  localparam int D = 4, H = 4, TO = 20, FULL = 1 << D;
  logic osc_clk = 0, reset = 0, sample_valid = 0, trig_slope = 0, rearm = 0;
  logic [7:0] sample_data = 0, trig_level = 0;
  logic out_valid, armed, capture_done, auto_trig;
  logic [7:0] out_data;
  int n_cmp = 0, n_bad = 0;
  int exp_q[$];
  bit mon_en = 0;
  int m_ph, m_lvl, m_slope, m_cnt, m_t;
  bit m_auto;

  always #5 osc_clk = ~osc_clk;

  trig_ctrl #(.DEPTH_LOG2(D), .HYST(H), .AUTO_TIMEOUT(TO)) dut (
    .osc_clk(osc_clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .rearm(rearm), .out_valid(out_valid),
    .out_data(out_data), .armed(armed), .capture_done(capture_done), .auto_trig(auto_trig)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phases: 0 idle-armed-low, 1 waiting for edge, 2 capturing, 3 buffer full.
  task automatic model(bit rs, bit ra, bit v, int d);
    int lo, hi;
    bit trig, to;
    if (rs || ra) begin
      m_ph = 0; m_lvl = trig_level; m_slope = trig_slope; m_cnt = 0; m_t = 0; m_auto = 0;
      return;
    end
    if (!v || m_ph == 3) return;
    if (m_ph == 2) begin
      exp_q.push_back(d);
      m_cnt++;
      if (m_cnt == FULL) m_ph = 3;
      return;
    end
    lo = (m_lvl - H < 0) ? 0 : m_lvl - H;
    hi = (m_lvl + H > 255) ? 255 : m_lvl + H;
    m_t++;
    trig = m_ph == 1 && (m_slope ? d <= m_lvl : d >= m_lvl);
    to = 0;
`ifdef TRIG_AUTO_EN
    to = m_t == TO;
`endif
    if (trig || to) begin
      exp_q.push_back(d);
      m_cnt = 1;
      m_ph = 2;
      m_auto = !trig;
    end else if (m_ph == 0 && (m_slope ? d >= hi : d <= lo)) m_ph = 1;
  endtask

  task automatic cyc(bit rs, bit ra, bit v, int d);
    @(negedge osc_clk);
    reset = rs; rearm = ra; sample_valid = v; sample_data = 8'(d);
    model(rs, ra, v, d);
    @(posedge osc_clk);
    #1;
    chk("armed", armed, 32'(m_ph < 2));
    chk("capture_done", capture_done, 32'(m_ph == 3));
    chk("auto_trig", auto_trig, 32'(m_auto));
  endtask

  task automatic feed(int s[$]);
    foreach (s[i]) cyc(0, 0, 1, s[i]);
  endtask

  task automatic run(int n, int base);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, base + i);
  endtask

  initial begin
    forever begin
      @(posedge osc_clk);
      #1;
      if (mon_en) begin
        chk("out_valid", out_valid, 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          if (out_valid === 1'b1) chk("out_data", out_data, 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int s[$];
    trig_level = 128; trig_slope = 0;
    cyc(1, 0, 0, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_valid", out_valid, 0);
    mon_en = 1;
    cyc(0, 0, 0, 0);
    s = '{100, 110, 127, 128};
    feed(s);
    run(20, 129);
    cyc(0, 1, 0, 0);
    s = '{126, 129, 126, 129, 126, 129, 124, 129};
    feed(s);
    run(18, 10);
    trig_level = 253; trig_slope = 1;
    cyc(0, 1, 0, 0);
    trig_level = 0; trig_slope = 0;
    s = '{255, 250};
    feed(s);
    run(16, 60);
    trig_level = 128;
    cyc(0, 1, 0, 0);
    s = '{100, 130};
    feed(s);
    run(6, 131);
    cyc(0, 1, 1, 77);
    s = '{200, 200, 100, 130};
    feed(s);
    run(17, 140);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    s = '{100, 130};
    feed(s);
    run(3, 180);
    cyc(1, 0, 1, 99);
    run(4, 150);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 45; i++) cyc(0, 0, 1, 50);
    for (int i = 0; i < 3000; i++) begin
      bit ra;
      ra = $urandom_range(0, 149) == 0;
      if (ra || $urandom_range(0, 19) == 0) begin
        trig_level = 8'($urandom_range(0, 255));
        trig_slope = 1'($urandom_range(0, 1));
      end
      cyc($urandom_range(0, 999) == 0, ra, $urandom_range(0, 9) < 7, $urandom_range(0, 255));
    end
    cyc(0, 0, 0, 0);
    chk("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
